// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/capture controller in front of the external 3-bit-op ALU.
// S1 holds the decoded op and operands driving the ALU; S2 captures the result for writeback.
module alu_issue_ctrl #(
  parameter int unsigned W    = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_aluop,
  input  logic [5:0]      in_funct,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic [2:0]      alu_op,
  output logic [W-1:0]    alu_data1,
  output logic [W-1:0]    alu_data2,
  input  logic [W-1:0]    alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_zero,
  output logic            out_illegal
);

  logic            s1_valid_q;
  logic [RD_W-1:0] s1_rd_q;
  logic            s1_illegal_q;
  logic            s2_adv;
  logic            s1_adv;
  logic            accept;
  logic [2:0]      dec_op;
  logic            dec_illegal;
  logic [W-1:0]    res_cap;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid & in_ready;

  // Illegal ops steer the ALU to 011 and also force the captured result to zero.
  assign res_cap = s1_illegal_q ? '0 : alu_result;

  always_comb begin
    dec_op      = 3'b011;
    dec_illegal = 1'b1;
    case (in_aluop)
      2'b00: begin
        dec_op      = 3'b010;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_op      = 3'b110;
        dec_illegal = 1'b0;
      end
      2'b10: begin
        dec_illegal = 1'b0;
        case (in_funct)
          6'b100000: dec_op = 3'b010;
          6'b100010: dec_op = 3'b110;
          6'b100100: dec_op = 3'b000;
          6'b100101: dec_op = 3'b001;
          6'b101010: dec_op = 3'b111;
          default: begin
            dec_op      = 3'b011;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_op      = 3'b011;
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_rd_q      <= '0;
      s1_illegal_q <= 1'b0;
      alu_op       <= 3'b000;
      alu_data1    <= '0;
      alu_data2    <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rd       <= '0;
      out_zero     <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      // Kill valids only; payload registers keep their contents.
      s1_valid_q <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q   <= 1'b1;
        s1_rd_q      <= in_rd;
        s1_illegal_q <= dec_illegal;
        alu_op       <= dec_op;
        alu_data1    <= in_a;
        alu_data2    <= in_b;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_valid_q && s2_adv) begin
        out_valid   <= 1'b1;
        out_result  <= res_cap;
        out_rd      <= s1_rd_q;
        out_zero    <= (res_cap == '0);
        out_illegal <= s1_illegal_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
